// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the memory access unit: FSM state encoding,
// default bus widths, the NOP encoding and instruction field positions.
package mips_mem_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int FN_MSB = 5;
    localparam int FN_LSB = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } mau_state_t;

    // Word accesses only: the two low byte-address bits must be zero.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mau_timeout_counter.sv
// Cycle counter used to abort a memory access that never completes.
// clear_i has priority over enable_i; the count saturates at LIMIT-1 so that
// expired_o stays asserted for as long as the counter remains enabled.
module mau_timeout_counter #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: restart on clear, advance while enabled, hold at the limit.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry fires in the LIMIT-th enabled cycle, so the owner leaves after
    // exactly LIMIT cycles of waiting.
    assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: converts the control FSM's memory-state intent into a
// req/gnt/rvalid transaction, owns the instruction register and the MDR,
// and stalls the control FSM until the access completes.
// Optional build macro: MEM_TIMEOUT_EN (abort stuck accesses after
// TIMEOUT_CYCLES cycles in REQ/WAIT_R).
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEFAULT,
    parameter int DATA_W         = DATA_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc_valid,
    input  logic              acc_is_instr,
    input  logic              acc_we,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              acc_stall,
    output logic              acc_err,
    output logic [DATA_W-1:0] instr,
    output logic [5:0]        operation,
    output logic [5:0]        func,
    output logic [DATA_W-1:0] mdr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    mau_state_t        state_q,     state_d;
    logic              fetch_q,     fetch_d;
    logic              wr_q,        wr_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] instr_q,     instr_d;
    logic [DATA_W-1:0] mdr_q,       mdr_d;
    logic              err_q,       err_d;

    logic [ADDR_W-1:0] sel_addr_s;
    logic              timeout_s;

    assign sel_addr_s = acc_is_instr ? pc : data_addr;

`ifdef MEM_TIMEOUT_EN
    logic tmo_clear_s;
    logic tmo_enable_s;

    // The counter is held clear while idle, so it starts from zero on REQ entry.
    assign tmo_clear_s  = (state_q == IDLE);
    assign tmo_enable_s = (state_q == REQ) || (state_q == WAIT_R);

    mau_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (tmo_clear_s),
        .enable_i  (tmo_enable_s),
        .expired_o (timeout_s)
    );
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output logic of the access FSM.
    always_comb begin
        state_d     = state_q;
        fetch_d     = fetch_q;
        wr_d        = wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        instr_d     = instr_q;
        mdr_d       = mdr_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (acc_valid) begin
                    if (is_word_aligned(sel_addr_s[1:0])) begin
                        fetch_d     = acc_is_instr;
                        wr_d        = acc_we & ~acc_is_instr;
                        mem_addr_d  = sel_addr_s;
                        mem_wdata_d = wdata;
                        state_d     = REQ;
                    end else begin
                        // Misaligned: flag and release the control FSM without a bus cycle.
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = wr_q ? DONE : WAIT_R;
                end else if (timeout_s) begin
                    err_d   = 1'b1;
                    instr_d = fetch_q ? DATA_W'(NOP_INSTR) : instr_q;
                    state_d = DONE;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    if (fetch_q) begin
                        instr_d = mem_rdata;
                    end else begin
                        mdr_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (timeout_s) begin
                    err_d   = 1'b1;
                    instr_d = fetch_q ? DATA_W'(NOP_INSTR) : instr_q;
                    state_d = DONE;
                end else begin
                    state_d = WAIT_R;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The request qualifiers are a registered image of "next state is REQ".
        mem_req_d = (state_d == REQ);
        mem_we_d  = (state_d == REQ) & wr_d;
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_q     <= 1'b0;
            wr_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            instr_q     <= DATA_W'(NOP_INSTR);
            mdr_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_q     <= fetch_d;
            wr_q        <= wr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            instr_q     <= instr_d;
            mdr_q       <= mdr_d;
            err_q       <= err_d;
        end
    end

    // Stall is the only combinational output: it must drop in the DONE cycle itself.
    assign acc_stall = acc_valid & (state_q != DONE);

    assign acc_err   = err_q;
    assign instr     = instr_q;
    assign operation = instr_q[OP_MSB:OP_LSB];
    assign func      = instr_q[FN_MSB:FN_LSB];
    assign mdr       = mdr_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit. Inputs change 1 time unit after
// the rising edge; outputs are checked 1 time unit later.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        acc_valid, acc_is_instr, acc_we;
    logic [31:0] pc, data_addr, wdata;
    logic        acc_stall, acc_err;
    logic [31:0] instr, mdr;
    logic [5:0]  operation, func;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .acc_valid    (acc_valid),
        .acc_is_instr (acc_is_instr),
        .acc_we       (acc_we),
        .pc           (pc),
        .data_addr    (data_addr),
        .wdata        (wdata),
        .acc_stall    (acc_stall),
        .acc_err      (acc_err),
        .instr        (instr),
        .operation    (operation),
        .func         (func),
        .mdr          (mdr),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; acc_valid = 1'b0; acc_is_instr = 1'b0; acc_we = 1'b0;
        pc = 32'h0; data_addr = 32'h0; wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #12;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_mdr", mdr, 32'h0);
        chk("rst_err", {31'b0, acc_err}, 32'd0);
        chk("rst_stall", {31'b0, acc_stall}, 32'd0);
        tick; rst_n = 1'b1;

        // 1: fetch with zero wait states
        tick; acc_valid = 1'b1; acc_is_instr = 1'b1; pc = 32'h0000_0004; #1;
        chk("t1_c0_stall", {31'b0, acc_stall}, 32'd1);
        chk("t1_c0_req", {31'b0, mem_req}, 32'd0);
        tick; mem_gnt = 1'b1; #1;
        chk("t1_c1_req", {31'b0, mem_req}, 32'd1);
        chk("t1_c1_addr", mem_addr, 32'h0000_0004);
        chk("t1_c1_we", {31'b0, mem_we}, 32'd0);
        chk("t1_c1_stall", {31'b0, acc_stall}, 32'd1);
        tick; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2008_0005; #1;
        chk("t1_c2_req", {31'b0, mem_req}, 32'd0);
        chk("t1_c2_stall", {31'b0, acc_stall}, 32'd1);
        tick; mem_rvalid = 1'b0; #1;
        chk("t1_c3_stall", {31'b0, acc_stall}, 32'd0);
        chk("t1_instr", instr, 32'h2008_0005);
        chk("t1_operation", {26'b0, operation}, 32'h08);
        chk("t1_func", {26'b0, func}, 32'h05);
        tick; acc_valid = 1'b0; #1;
        chk("t1_c4_idle_stall", {31'b0, acc_stall}, 32'd0);

        // 2: load, 3 grant waits and 2 rvalid waits, DONE in cycle 8
        for (int c = 0; c <= 8; c++) begin
            tick;
            acc_valid = 1'b1; acc_is_instr = 1'b0; acc_we = 1'b0;
            data_addr = 32'h0000_0040; pc = 32'h0000_0100;
            mem_gnt = (c == 4);
            mem_rvalid = (c == 7);
            mem_rdata = (c == 7) ? 32'hDEAD_BEEF : 32'h5555_5555;
            #1;
            chk($sformatf("t2_c%0d_stall", c), {31'b0, acc_stall}, (c == 8) ? 32'd0 : 32'd1);
            if (c >= 1 && c <= 4) begin
                chk($sformatf("t2_c%0d_req", c), {31'b0, mem_req}, 32'd1);
                chk($sformatf("t2_c%0d_addr", c), mem_addr, 32'h0000_0040);
            end
        end
        chk("t2_mdr", mdr, 32'hDEAD_BEEF);
        chk("t2_instr_kept", instr, 32'h2008_0005);
        tick; acc_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; #1;

        // 3: store with one grant wait and spurious rvalids
        tick; acc_valid = 1'b1; acc_we = 1'b1; data_addr = 32'h0000_0044;
        wdata = 32'h1234_5678; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF; #1;
        chk("t3_c0_stall", {31'b0, acc_stall}, 32'd1);
        tick; wdata = 32'h0; #1;
        chk("t3_c1_req", {31'b0, mem_req}, 32'd1);
        chk("t3_c1_we", {31'b0, mem_we}, 32'd1);
        chk("t3_c1_addr", mem_addr, 32'h0000_0044);
        chk("t3_c1_wdata", mem_wdata, 32'h1234_5678);
        tick; mem_gnt = 1'b1; #1;
        chk("t3_c2_req", {31'b0, mem_req}, 32'd1);
        chk("t3_c2_we", {31'b0, mem_we}, 32'd1);
        chk("t3_c2_wdata", mem_wdata, 32'h1234_5678);
        chk("t3_c2_stall", {31'b0, acc_stall}, 32'd1);
        tick; mem_gnt = 1'b0; #1;
        chk("t3_c3_stall", {31'b0, acc_stall}, 32'd0);
        chk("t3_c3_req", {31'b0, mem_req}, 32'd0);
        chk("t3_c3_we", {31'b0, mem_we}, 32'd0);
        tick; acc_valid = 1'b0; acc_we = 1'b0; mem_rvalid = 1'b0; #1;
        chk("t3_mdr_kept", mdr, 32'hDEAD_BEEF);
        chk("t3_instr_kept", instr, 32'h2008_0005);
        chk("t3_err_clear", {31'b0, acc_err}, 32'd0);

        // 4: misaligned data access
        tick; acc_valid = 1'b1; data_addr = 32'h0000_0042; #1;
        chk("t4_c0_stall", {31'b0, acc_stall}, 32'd1);
        tick; #1;
        chk("t4_c1_stall", {31'b0, acc_stall}, 32'd0);
        chk("t4_c1_req", {31'b0, mem_req}, 32'd0);
        chk("t4_c1_err", {31'b0, acc_err}, 32'd1);
        tick; acc_valid = 1'b0; #1;
        chk("t4_c2_req", {31'b0, mem_req}, 32'd0);
        tick; tick; #1;
        chk("t4_err_sticky", {31'b0, acc_err}, 32'd1);
        chk("t4_mdr_kept", mdr, 32'hDEAD_BEEF);

        // 5: reset while waiting for read data, then a late rvalid
        tick; acc_valid = 1'b1; acc_is_instr = 1'b1; pc = 32'h0000_0008; #1;
        tick; mem_gnt = 1'b1; #1;
        tick; mem_gnt = 1'b0; #1;
        chk("t5_wait_req", {31'b0, mem_req}, 32'd0);
        chk("t5_wait_stall", {31'b0, acc_stall}, 32'd1);
        rst_n = 1'b0; #1;
        chk("t5_rst_req", {31'b0, mem_req}, 32'd0);
        chk("t5_rst_instr", instr, 32'h0);
        chk("t5_rst_mdr", mdr, 32'h0);
        chk("t5_rst_err", {31'b0, acc_err}, 32'd0);
        tick; rst_n = 1'b1; acc_valid = 1'b0; #1;
        tick; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
        tick; mem_rvalid = 1'b0; #1;
        chk("t5_late_instr", instr, 32'h0);
        chk("t5_late_mdr", mdr, 32'h0);
        chk("t5_late_req", {31'b0, mem_req}, 32'd0);
        acc_valid = 1'b1; pc = 32'h0000_000C; #1;
        chk("t5_idle_stall", {31'b0, acc_stall}, 32'd1);
        tick; mem_gnt = 1'b1; #1;
        chk("t5_new_req", {31'b0, mem_req}, 32'd1);
        chk("t5_new_addr", mem_addr, 32'h0000_000C);
        tick; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h8C43_0010; #1;
        tick; mem_rvalid = 1'b0; #1;
        chk("t5_new_stall", {31'b0, acc_stall}, 32'd0);
        chk("t5_new_instr", instr, 32'h8C43_0010);
        chk("t5_new_op", {26'b0, operation}, 32'h23);
        chk("t5_new_fn", {26'b0, func}, 32'h10);
        tick; acc_valid = 1'b0; #1;

`ifdef MEM_TIMEOUT_EN
        // 6: read data never arrives, abort after 4 cycles in REQ/WAIT_R
        for (int c = 0; c <= 5; c++) begin
            tick;
            acc_valid = 1'b1; acc_is_instr = 1'b1; pc = 32'h0000_0010;
            mem_gnt = (c == 1);
            #1;
            chk($sformatf("t6_c%0d_stall", c), {31'b0, acc_stall}, (c == 5) ? 32'd0 : 32'd1);
        end
        chk("t6_err", {31'b0, acc_err}, 32'd1);
        chk("t6_instr_nop", instr, 32'h0);
        chk("t6_req", {31'b0, mem_req}, 32'd0);
        tick; acc_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0; #1;
        tick; mem_rvalid = 1'b0; #1;
        chk("t6_late_instr", instr, 32'h0);
        chk("t6_late_mdr", mdr, 32'h0);
        chk("t6_err_sticky", {31'b0, acc_err}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
